router_forward_arbiter: RTL and testbench

ROUTER_FORWARD_ARBITER -- requirements
Module: router_forward_arbiter

---
 rtl/router_forward_arbiter.sv | 161 ++++++++++++++++
 tb/tb_router_forward_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/router_forward_arbiter.sv
// Two-input router stage: per-input FIFOs feeding independent round-robin
// arbiters for the forward hop (dy adjusted) and the local sink (dy stripped).
module router_forward_arbiter #(
    parameter int DATA_WIDTH = 23,
    parameter int DY_MSB     = 20,
    parameter int DY_LSB     = 12,
    parameter int ADD        = 1,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [DATA_WIDTH-1:0]                       a_din,
    input  logic                                        a_wen,
    output logic                                        a_full,
    input  logic [DATA_WIDTH-1:0]                       b_din,
    input  logic                                        b_wen,
    output logic                                        b_full,
    output logic [DATA_WIDTH-1:0]                       fwd_dout,
    output logic                                        fwd_wen,
    input  logic                                        fwd_full,
    output logic [DATA_WIDTH-(DY_MSB-DY_LSB+1)-1:0]     local_dout,
    output logic                                        local_wen,
    input  logic                                        local_full,
    output logic                                        overflow
);

    localparam int DY_W  = DY_MSB - DY_LSB + 1;
    localparam int LOC_W = DATA_WIDTH - DY_W;
    localparam int PTR_W = $clog2(BUF_DEPTH);

    // Index 0 is input A, index 1 is input B throughout.
    logic [DATA_WIDTH-1:0] mem_q  [2][BUF_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d  [2][BUF_DEPTH];
    logic [PTR_W:0]        wr_q   [2];
    logic [PTR_W:0]        wr_d   [2];
    logic [PTR_W:0]        rd_q   [2];
    logic [PTR_W:0]        rd_d   [2];
    logic                  fwd_ptr_q, fwd_ptr_d;
    logic                  loc_ptr_q, loc_ptr_d;
    logic                  overflow_q, overflow_d;

    logic [DATA_WIDTH-1:0] din_s  [2];
    logic [DATA_WIDTH-1:0] head_s [2];
    logic [LOC_W-1:0]      strip_s[2];
    logic [1:0]            wen_s, full_s, empty_s, is_local_s;
    logic [1:0]            fwd_el_s, loc_el_s, fwd_gnt_s, loc_gnt_s, pop_s;
    logic [DATA_WIDTH-1:0] fwd_sel_s;
    logic [DY_W-1:0]       dy_sum_s;

    assign din_s[0] = a_din;
    assign din_s[1] = b_din;
    assign wen_s    = {b_wen, a_wen};

    // FIFO status, head decode and per-destination eligibility.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            head_s[i]     = mem_q[i][rd_q[i][PTR_W-1:0]];
            full_s[i]     = ((wr_q[i] - rd_q[i]) == (PTR_W+1)'(BUF_DEPTH));
            empty_s[i]    = (wr_q[i] == rd_q[i]);
            is_local_s[i] = (head_s[i][DY_MSB:DY_LSB] == DY_W'(0));
            fwd_el_s[i]   = !empty_s[i] && !is_local_s[i] && !fwd_full;
            loc_el_s[i]   = !empty_s[i] &&  is_local_s[i] && !local_full;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_strip
        if (DY_MSB == DATA_WIDTH - 1) begin : g_top
            assign strip_s[g] = head_s[g][DY_LSB-1:0];
        end else begin : g_mid
            assign strip_s[g] = {head_s[g][DATA_WIDTH-1:DY_MSB+1], head_s[g][DY_LSB-1:0]};
        end
    end

    // Independent round-robin arbitration; pointer moves to the loser after a grant.
    always_comb begin
        fwd_gnt_s = fwd_el_s;
        loc_gnt_s = loc_el_s;
        fwd_ptr_d = fwd_ptr_q;
        loc_ptr_d = loc_ptr_q;
        if (fwd_el_s == 2'b11) begin
            fwd_gnt_s = fwd_ptr_q ? 2'b10 : 2'b01;
        end else begin
            fwd_gnt_s = fwd_el_s;
        end
        if (loc_el_s == 2'b11) begin
            loc_gnt_s = loc_ptr_q ? 2'b10 : 2'b01;
        end else begin
            loc_gnt_s = loc_el_s;
        end
        if (fwd_gnt_s[0]) begin
            fwd_ptr_d = 1'b1;
        end else if (fwd_gnt_s[1]) begin
            fwd_ptr_d = 1'b0;
        end else begin
            fwd_ptr_d = fwd_ptr_q;
        end
        if (loc_gnt_s[0]) begin
            loc_ptr_d = 1'b1;
        end else if (loc_gnt_s[1]) begin
            loc_ptr_d = 1'b0;
        end else begin
            loc_ptr_d = loc_ptr_q;
        end
        pop_s = fwd_gnt_s | loc_gnt_s;
    end

    // FIFO next state; full is sampled before this cycle's pop, so a pop never admits a write.
    always_comb begin
        mem_d      = mem_q;
        overflow_d = overflow_q | (|(wen_s & full_s));
        for (int i = 0; i < 2; i++) begin
            wr_d[i] = wr_q[i];
            rd_d[i] = rd_q[i] + (PTR_W+1)'(pop_s[i]);
            if (wen_s[i] && !full_s[i]) begin
                mem_d[i][wr_q[i][PTR_W-1:0]] = din_s[i];
                wr_d[i] = wr_q[i] + (PTR_W+1)'(1);
            end else begin
                wr_d[i] = wr_q[i];
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                wr_q[i] <= '0;
                rd_q[i] <= '0;
                for (int j = 0; j < BUF_DEPTH; j++) begin
                    mem_q[i][j] <= '0;
                end
            end
            fwd_ptr_q  <= 1'b0;
            loc_ptr_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            fwd_ptr_q  <= fwd_ptr_d;
            loc_ptr_q  <= loc_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Output datapath: A's head is presented whenever B is not granted.
    always_comb begin
        fwd_sel_s = fwd_gnt_s[1] ? head_s[1] : head_s[0];
        dy_sum_s  = fwd_sel_s[DY_MSB:DY_LSB] + DY_W'(ADD);
        fwd_dout  = fwd_sel_s;
        fwd_dout[DY_MSB:DY_LSB] = dy_sum_s;
        local_dout = loc_gnt_s[1] ? strip_s[1] : strip_s[0];
    end

    assign fwd_wen   = |fwd_gnt_s;
    assign local_wen = |loc_gnt_s;
    assign a_full    = full_s[0];
    assign b_full    = full_s[1];
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_router_forward_arbiter.sv
// Directed stimulus with a queue scoreboard; a negedge monitor checks every
// fwd/local write against the hand-computed expected packets in order.
module tb_router_forward_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [22:0] a_din = 23'h0, b_din = 23'h0;
    logic        a_wen = 1'b0, b_wen = 1'b0;
    logic        a_full, b_full;
    logic [22:0] fwd_dout;
    logic        fwd_wen;
    logic        fwd_full = 1'b0;
    logic [13:0] local_dout;
    logic        local_wen;
    logic        local_full = 1'b0;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    logic [22:0] fwd_q[$];
    logic [13:0] loc_q[$];

    router_forward_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_din(a_din), .a_wen(a_wen), .a_full(a_full),
        .b_din(b_din), .b_wen(b_wen), .b_full(b_full),
        .fwd_dout(fwd_dout), .fwd_wen(fwd_wen), .fwd_full(fwd_full),
        .local_dout(local_dout), .local_wen(local_wen), .local_full(local_full),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every output write must match the oldest expected packet.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fwd_wen) begin
                if (fwd_q.size() == 0) begin
                    chk("fwd_unexpected", {9'h0, fwd_dout}, 32'hFFFFFFFF);
                end else begin
                    chk("fwd_data", {9'h0, fwd_dout}, {9'h0, fwd_q.pop_front()});
                end
            end
            if (local_wen) begin
                if (loc_q.size() == 0) begin
                    chk("local_unexpected", {18'h0, local_dout}, 32'hFFFFFFFF);
                end else begin
                    chk("local_data", {18'h0, local_dout}, {18'h0, loc_q.pop_front()});
                end
            end
        end
    end

    initial begin
        // Reset state
        #12;
        chk("rst_a_full", {31'h0, a_full}, 32'h0);
        chk("rst_b_full", {31'h0, b_full}, 32'h0);
        chk("rst_fwd_wen", {31'h0, fwd_wen}, 32'h0);
        chk("rst_local_wen", {31'h0, local_wen}, 32'h0);
        chk("rst_overflow", {31'h0, overflow}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single forward packet, dy=1 -> dy=2, one-cycle latency
        a_din = 23'h001005; a_wen = 1'b1; fwd_q.push_back(23'h002005);
        tick();
        a_wen = 1'b0;
        chk("lat_fwd_wen", {31'h0, fwd_wen}, 32'h1);
        chk("lat_fwd_dout", {9'h0, fwd_dout}, 32'h002005);
        chk("lat_local_wen", {31'h0, local_wen}, 32'h0);
        tick();

        // Both local in one cycle: A then B (pointer 0 -> 1 -> 0)
        a_din = 23'h600123; a_wen = 1'b1; loc_q.push_back(14'h3123);
        b_din = 23'h200456; b_wen = 1'b1; loc_q.push_back(14'h1456);
        tick();
        a_wen = 1'b0; b_wen = 1'b0;
        chk("rr_first_a", {18'h0, local_dout}, 32'h3123);
        tick();
        chk("rr_second_b", {18'h0, local_dout}, 32'h1456);
        tick();

        // A alone moves pointer to B; then a simultaneous pair grants B first
        a_din = 23'h000011; a_wen = 1'b1; loc_q.push_back(14'h0011);
        tick();
        a_wen = 1'b0;
        tick();
        a_din = 23'h000022; a_wen = 1'b1; loc_q.push_back(14'h0033);
        b_din = 23'h000033; b_wen = 1'b1; loc_q.push_back(14'h0022);
        tick();
        a_wen = 1'b0; b_wen = 1'b0;
        chk("rr_ptr_b_first", {18'h0, local_dout}, 32'h0033);
        tick(); tick();

        // Dual grant: A forward (dy=3), B local, same cycle
        a_din = 23'h003077; a_wen = 1'b1; fwd_q.push_back(23'h004077);
        b_din = 23'h000099; b_wen = 1'b1; loc_q.push_back(14'h0099);
        tick();
        a_wen = 1'b0; b_wen = 1'b0;
        chk("dual_fwd_wen", {31'h0, fwd_wen}, 32'h1);
        chk("dual_local_wen", {31'h0, local_wen}, 32'h1);
        tick();
        chk("dual_popped_fwd", {31'h0, fwd_wen}, 32'h0);
        chk("dual_popped_loc", {31'h0, local_wen}, 32'h0);
        tick();

        // Backpressure: five forward writes into A while fwd_full, B local still flows
        fwd_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            a_din = 23'h005100 + 23'(k); a_wen = 1'b1;
            if (k < 4) fwd_q.push_back(23'h006100 + 23'(k));
            if (k == 1) begin
                b_din = 23'h000AAA; b_wen = 1'b1; loc_q.push_back(14'h0AAA);
            end
            tick();
            a_wen = 1'b0; b_wen = 1'b0;
            chk("bp_fwd_blocked", {31'h0, fwd_wen}, 32'h0);
            if (k == 3) chk("bp_a_full", {31'h0, a_full}, 32'h1);
            if (k == 3) chk("bp_no_ovf_yet", {31'h0, overflow}, 32'h0);
            if (k == 4) chk("bp_overflow", {31'h0, overflow}, 32'h1);
        end
        tick();
        fwd_full = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("bp_drained", {31'h0, a_full}, 32'h0);
        chk("ovf_sticky", {31'h0, overflow}, 32'h1);

        // dy=-1 forwards and wraps to 0; dy=0x0FF -> 0x100
        a_din = 23'h1FF321; a_wen = 1'b1; fwd_q.push_back(23'h000321);
        tick();
        a_wen = 1'b0;
        chk("wrap_neg1", {9'h0, fwd_dout}, 32'h000321);
        tick();
        a_din = 23'h0FF654; a_wen = 1'b1; fwd_q.push_back(23'h100654);
        tick();
        a_wen = 1'b0;
        chk("wrap_0ff", {9'h0, fwd_dout}, 32'h100654);
        tick();

        // Mid-stream reset with three packets buffered
        fwd_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a_din = 23'h00F000 + 23'(k); a_wen = 1'b1;
            tick();
        end
        a_wen = 1'b0;
        fwd_full = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_fwd_wen", {31'h0, fwd_wen}, 32'h0);
        chk("mrst_local_wen", {31'h0, local_wen}, 32'h0);
        chk("mrst_a_full", {31'h0, a_full}, 32'h0);
        chk("mrst_overflow", {31'h0, overflow}, 32'h0);
        tick(); tick();
        @(negedge clk);
        rst_n = 1'b1;
        a_din = 23'h002ABC; a_wen = 1'b1; fwd_q.push_back(23'h003ABC);
        @(posedge clk);
        #1;
        a_wen = 1'b0;
        chk("post_rst_write", {31'h0, fwd_wen}, 32'h1);
        chk("post_rst_dout", {9'h0, fwd_dout}, 32'h003ABC);
        for (int k = 0; k < 5; k++) tick();

        // Bounded wait for the scoreboard to empty
        for (int k = 0; k < 50; k++) begin
            if (fwd_q.size() == 0 && loc_q.size() == 0) break;
            tick();
        end
        chk("fwd_q_empty", fwd_q.size(), 32'h0);
        chk("loc_q_empty", loc_q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
